// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: memory opcodes, size field, FSM states.
package lsu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned REG_W  = 5;

   localparam logic [OP_W-1:0] EXE_LB  = 6'b100000;
   localparam logic [OP_W-1:0] EXE_LH  = 6'b100001;
   localparam logic [OP_W-1:0] EXE_LW  = 6'b100011;
   localparam logic [OP_W-1:0] EXE_LBU = 6'b100100;
   localparam logic [OP_W-1:0] EXE_LHU = 6'b100101;
   localparam logic [OP_W-1:0] EXE_SB  = 6'b101000;
   localparam logic [OP_W-1:0] EXE_SH  = 6'b101001;
   localparam logic [OP_W-1:0] EXE_SW  = 6'b101011;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_BUS  = 2'd1,
      LSU_DONE = 2'd2,
      LSU_ERR  = 2'd3
   } lsu_state_t;

   function automatic logic is_mem_op(input logic [OP_W-1:0] op);
      return (op == EXE_LB)  || (op == EXE_LH)  || (op == EXE_LW) ||
             (op == EXE_LBU) || (op == EXE_LHU) || (op == EXE_SB) ||
             (op == EXE_SH)  || (op == EXE_SW);
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store side produces write enables and replicated data,
// load side selects the addressed lane and sign/zero-extends it.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic              store,
   input  logic              uns,
   input  logic [1:0]        size,
   input  logic [1:0]        off,
   input  logic [DATA_W-1:0] din,
   output logic [3:0]        wen,
   output logic [DATA_W-1:0] dout
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      case (off)
         2'd1:    b = din[15:8];
         2'd2:    b = din[23:16];
         2'd3:    b = din[31:24];
         default: b = din[7:0];
      endcase
      h    = off[1] ? din[31:16] : din[15:0];
      wen  = 4'b0000;
      dout = din;
      if (store) begin
         case (size)
            SZ_BYTE: begin
               wen  = 4'b0001 << off;
               dout = {4{din[7:0]}};
            end
            SZ_HALF: begin
               wen  = off[1] ? 4'b1100 : 4'b0011;
               dout = {2{din[15:0]}};
            end
            SZ_WORD: wen = 4'b1111;
            default: ;
         endcase
      end else begin
         case (size)
            SZ_BYTE: dout = {{24{b[7] & ~uns}}, b};
            SZ_HALF: dout = {{16{h[15] & ~uns}}, h};
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: request latch, req/ack bus sequencing and load writeback.
// LSU_ALIGN_CHECK_EN enables the address-error path (adel/ades/badvaddr).
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [REG_W-1:0]  req_rd,
   output logic              mem_en,
   output logic [3:0]        mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_W-1:0]  wb_rd,
   output logic              st_done,
   output logic              adel,
   output logic              ades,
   output logic [ADDR_W-1:0] badvaddr
);

   lsu_state_t        state;
   logic              op_store;
   logic              op_uns;
   logic [1:0]        op_size;
   logic [1:0]        op_off;
   logic [REG_W-1:0]  rd_q;
   logic              accept;
   logic              bad_align;
   logic [3:0]        st_wen;
   logic [DATA_W-1:0] st_wdata;
   logic [3:0]        ld_wen_unused;
   logic [DATA_W-1:0] ld_data;

   assign accept = (state == LSU_IDLE) && req_valid && is_mem_op(req_op);

`ifdef LSU_ALIGN_CHECK_EN
   assign bad_align = misaligned(req_op[1:0], req_addr[1:0]);
`else
   assign bad_align = 1'b0;
`endif

   // Store lanes are formed from the live request so they can be registered at accept.
   lsu_lane u_st_lane (
      .store (req_op[3]),
      .uns   (req_op[2]),
      .size  (req_op[1:0]),
      .off   (req_addr[1:0]),
      .din   (req_wdata),
      .wen   (st_wen),
      .dout  (st_wdata)
   );

   // Load side never writes; its enables are left dangling.
   lsu_lane u_ld_lane (
      .store (1'b0),
      .uns   (op_uns),
      .size  (op_size),
      .off   (op_off),
      .din   (mem_rdata),
      .wen   (ld_wen_unused),
      .dout  (ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LSU_IDLE;
         req_ready <= 1'b1;
         mem_en    <= 1'b0;
         mem_wen   <= 4'b0000;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wb_valid  <= 1'b0;
         wb_data   <= '0;
         wb_rd     <= '0;
         st_done   <= 1'b0;
         op_store  <= 1'b0;
         op_uns    <= 1'b0;
         op_size   <= 2'b00;
         op_off    <= 2'b00;
         rd_q      <= '0;
      end else begin
         wb_valid <= 1'b0;
         st_done  <= 1'b0;
         case (state)
            LSU_IDLE: begin
               if (accept) begin
                  op_store  <= req_op[3];
                  op_uns    <= req_op[2];
                  op_size   <= req_op[1:0];
                  op_off    <= req_addr[1:0];
                  rd_q      <= req_rd;
                  req_ready <= 1'b0;
                  if (bad_align) begin
                     state <= LSU_ERR;
                  end else begin
                     state     <= LSU_BUS;
                     mem_en    <= 1'b1;
                     mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_wen   <= st_wen;
                     mem_wdata <= st_wdata;
                  end
               end
            end
            LSU_BUS: begin
               if (mem_ack) begin
                  state   <= LSU_DONE;
                  mem_en  <= 1'b0;
                  mem_wen <= 4'b0000;
                  if (op_store) begin
                     st_done <= 1'b1;
                  end else begin
                     wb_valid <= 1'b1;
                     wb_data  <= ld_data;
                     wb_rd    <= rd_q;
                  end
               end
            end
            LSU_DONE: begin
               state     <= LSU_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= LSU_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef LSU_ALIGN_CHECK_EN
   // Error pulse is registered at accept so it lines up with the single ERR cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         adel     <= 1'b0;
         ades     <= 1'b0;
         badvaddr <= '0;
      end else begin
         adel <= accept && bad_align && !req_op[3];
         ades <= accept && bad_align && req_op[3];
         if (accept && bad_align) begin
            badvaddr <= req_addr;
         end
      end
   end
`else
   assign adel     = 1'b0;
   assign ades     = 1'b0;
   assign badvaddr = '0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed plan vectors plus randomized transactions
// checked against an arithmetic reference model; adapts to LSU_ALIGN_CHECK_EN.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        st_done;
   logic        adel;
   logic        ades;
   logic [31:0] badvaddr;

   int vectors;
   int miscompares;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   lsu_ctrl #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_rd    (req_rd),
      .mem_en    (mem_en),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .wb_valid  (wb_valid),
      .wb_data   (wb_data),
      .wb_rd     (wb_rd),
      .st_done   (st_done),
      .adel      (adel),
      .ades      (ades),
      .badvaddr  (badvaddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain arithmetic on the access size and byte offset.
   function automatic bit model_misaligned(input logic [5:0] op, input logic [31:0] addr);
`ifdef LSU_ALIGN_CHECK_EN
      int unsigned off = 32'(addr[1:0]);
      if (op[1:0] == 2'b01) return (off % 2) != 0;
      if (op[1:0] == 2'b11) return off != 0;
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] model_wen(input logic [5:0] op, input logic [31:0] addr);
      int unsigned off = 32'(addr[1:0]);
      if (!op[3]) return 4'h0;
      if (op[1:0] == 2'b00) return 4'(1 << off);
      if (op[1:0] == 2'b01) return 4'(3 << (2 * (off / 2)));
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] b);
      if (op[1:0] == 2'b00) return (b & 32'hFF) * 32'h0101_0101;
      if (op[1:0] == 2'b01) return (b & 32'hFFFF) * 32'h0001_0001;
      return b;
   endfunction

   function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      int unsigned off = 32'(addr[1:0]);
      logic [31:0] v;
      if (op[1:0] == 2'b00) begin
         v = (rdata >> (8 * off)) & 32'hFF;
         if (!op[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end else if (op[1:0] == 2'b01) begin
         v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
         if (!op[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   // Drives one request from an IDLE negedge and follows it to the next IDLE negedge.
   // With hold set, req_valid stays high presenting the following request meanwhile.
   task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                          input bit hold, input logic [5:0] nop, input logic [31:0] naddr,
                          input logic [31:0] nwdata, input logic [4:0] nrd);
      bit          st;
      bit          bad;
      logic [3:0]  ew;
      logic [31:0] ea;
      logic [31:0] ed;
      logic [31:0] el;
      st  = op[3];
      bad = model_misaligned(op, addr);
      ew  = model_wen(op, addr);
      ea  = addr & 32'hFFFF_FFFC;
      ed  = model_wdata(op, wdata);
      el  = model_load(op, addr, rdata);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      req_rd    = rd;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_at_issue op=%b addr=%h got=%b exp=1", op, addr, req_ready);
      end
      @(negedge clk);
      if (hold) begin
         req_op    = nop;
         req_addr  = naddr;
         req_wdata = nwdata;
         req_rd    = nrd;
      end else begin
         req_valid = 1'b0;
      end
      if (bad) begin
         vectors++;
         if ({adel, ades, mem_en, req_ready} !== {!st, st, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL err_pulse addr=%h got adel/ades/en/rdy=%b%b%b%b exp=%b%b00",
                     addr, adel, ades, mem_en, req_ready, !st, st);
         end
         vectors++;
         if (badvaddr !== addr) begin
            miscompares++;
            $display("FAIL badvaddr got=%h exp=%h", badvaddr, addr);
         end
         @(negedge clk);
         vectors++;
         if ({adel, ades, mem_en, req_ready, wb_valid, st_done} !== 6'b000100) begin
            miscompares++;
            $display("FAIL err_recover got=%b exp=000100",
                     {adel, ades, mem_en, req_ready, wb_valid, st_done});
         end
         return;
      end
      for (int k = 0; k <= delay; k++) begin
         vectors++;
         if ({mem_en, mem_wen, mem_addr} !== {1'b1, ew, ea}) begin
            miscompares++;
            $display("FAIL bus_hold op=%b cyc=%0d got en=%b wen=%b addr=%h exp en=1 wen=%b addr=%h",
                     op, k, mem_en, mem_wen, mem_addr, ew, ea);
         end
         if (st) begin
            vectors++;
            if (mem_wdata !== ed) begin
               miscompares++;
               $display("FAIL store_wdata op=%b cyc=%0d got=%h exp=%h", op, k, mem_wdata, ed);
            end
         end
         vectors++;
         if ({req_ready, wb_valid, st_done, adel, ades} !== 5'b00000) begin
            miscompares++;
            $display("FAIL bus_quiet cyc=%0d got rdy/wb/st/adel/ades=%b exp=00000",
                     k, {req_ready, wb_valid, st_done, adel, ades});
         end
         mem_ack   = (k == delay);
         mem_rdata = (k == delay) ? rdata : $urandom;
         @(negedge clk);
      end
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      vectors++;
      if ({wb_valid, st_done, mem_en, req_ready, adel, ades} !== {!st, st, 4'b0000}) begin
         miscompares++;
         $display("FAIL done_strobe op=%b got wb/st/en/rdy/adel/ades=%b exp=%b%b0000",
                  op, {wb_valid, st_done, mem_en, req_ready, adel, ades}, !st, st);
      end
      if (!st) begin
         vectors++;
         if ({wb_data, wb_rd} !== {el, rd}) begin
            miscompares++;
            $display("FAIL load_data op=%b addr=%h got=%h/%0d exp=%h/%0d",
                     op, addr, wb_data, wb_rd, el, rd);
         end
      end
      @(negedge clk);
      vectors++;
      if ({wb_valid, st_done, mem_en, req_ready} !== 4'b0001) begin
         miscompares++;
         $display("FAIL back_idle got wb/st/en/rdy=%b exp=0001",
                  {wb_valid, st_done, mem_en, req_ready});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({req_ready, mem_en, mem_wen, wb_valid, st_done, adel, ades} !== 10'b1_0_0000_0000) begin
         miscompares++;
         $display("FAIL reset_ctrl got=%b exp=1000000000",
                  {req_ready, mem_en, mem_wen, wb_valid, st_done, adel, ades});
      end
      vectors++;
      if ({mem_addr, mem_wdata, wb_data, wb_rd, badvaddr} !== '0) begin
         miscompares++;
         $display("FAIL reset_data got addr=%h wd=%h wb=%h rd=%0d bad=%h exp all 0",
                  mem_addr, mem_wdata, wb_data, wb_rd, badvaddr);
      end
   endtask

   task automatic test_directed();
      run_txn(OP_LW,  32'h100, 32'h0, 5'd7,  32'hDEAD_BEEF, 0, 0, '0, '0, '0, '0);
      run_txn(OP_LB,  32'h103, 32'h0, 5'd3,  32'h80FF_0000, 0, 0, '0, '0, '0, '0);
      run_txn(OP_LBU, 32'h103, 32'h0, 5'd4,  32'h80FF_0000, 0, 0, '0, '0, '0, '0);
      run_txn(OP_LH,  32'h102, 32'h0, 5'd5,  32'h80FF_0000, 0, 0, '0, '0, '0, '0);
      run_txn(OP_LHU, 32'h100, 32'h0, 5'd6,  32'h1234_8001, 0, 0, '0, '0, '0, '0);
      run_txn(OP_SB,  32'h201, 32'h0000_00A5, 5'd0, 32'h0, 0, 0, '0, '0, '0, '0);
      run_txn(OP_SH,  32'h202, 32'h0000_1234, 5'd0, 32'h0, 1, 0, '0, '0, '0, '0);
      run_txn(OP_SW,  32'h204, 32'hCAFE_F00D, 5'd0, 32'h0, 0, 0, '0, '0, '0, '0);
   endtask

   task automatic test_back_to_back();
      // Next request held valid during a slow ack; it must only be taken once IDLE.
      run_txn(OP_LW, 32'h300, 32'h0, 5'd9, 32'h0BAD_CAFE, 3, 1, OP_SW, 32'h400, 32'h5555_AAAA, 5'd1);
      run_txn(OP_SW, 32'h400, 32'h5555_AAAA, 5'd1, 32'h0, 2, 0, '0, '0, '0, '0);
   endtask

   task automatic test_misaligned();
      run_txn(OP_LW, 32'h102, 32'h0, 5'd8, 32'h1122_3344, 0, 0, '0, '0, '0, '0);
      run_txn(OP_SH, 32'h301, 32'hBEEF, 5'd0, 32'h0, 0, 0, '0, '0, '0, '0);
      run_txn(OP_LHU, 32'h103, 32'h0, 5'd2, 32'hF00D_8899, 1, 0, '0, '0, '0, '0);
   endtask

   task automatic test_nonmem();
      req_valid = 1'b1;
      req_op    = 6'b001000;
      req_addr  = 32'h500;
      mem_ack   = 1'b1;
      mem_rdata = 32'h7777_7777;
      @(negedge clk);
      req_op = 6'b101010;
      vectors++;
      if ({mem_en, req_ready, wb_valid, st_done, adel, ades} !== 6'b010000) begin
         miscompares++;
         $display("FAIL nonmem_drop got en/rdy/wb/st/adel/ades=%b exp=010000",
                  {mem_en, req_ready, wb_valid, st_done, adel, ades});
      end
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if ({mem_en, req_ready, wb_valid, st_done, adel, ades} !== 6'b010000) begin
         miscompares++;
         $display("FAIL idle_ack_ignored got=%b exp=010000",
                  {mem_en, req_ready, wb_valid, st_done, adel, ades});
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_reset_in_bus();
      req_valid = 1'b1;
      req_op    = OP_LW;
      req_addr  = 32'h600;
      req_rd    = 5'd11;
      @(negedge clk);
      req_valid = 1'b0;
      vectors++;
      if (mem_en !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pre_bus got mem_en=%b exp=1", mem_en);
      end
      rst       = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_5678;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({mem_en, req_ready, wb_valid, st_done} !== 4'b0100) begin
         miscompares++;
         $display("FAIL rst_abort got en/rdy/wb/st=%b exp=0100", {mem_en, req_ready, wb_valid, st_done});
      end
      @(negedge clk);
      mem_ack = 1'b0;
      vectors++;
      if ({mem_en, req_ready, wb_valid, st_done} !== 4'b0100) begin
         miscompares++;
         $display("FAIL rst_no_wb got en/rdy/wb/st=%b exp=0100", {mem_en, req_ready, wb_valid, st_done});
      end
   endtask

   task automatic test_random();
      logic [5:0]  ops [8];
      logic [31:0] addr;
      ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
      for (int i = 0; i < 60; i++) begin
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr[1:0] = 2'(2 * $urandom_range(0, 1));
         run_txn(ops[$urandom_range(0, 7)], addr, $urandom, 5'($urandom_range(0, 31)),
                 $urandom, $urandom_range(0, 3), 0, '0, '0, '0, '0);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_misaligned();
      test_nonmem();
      test_reset_in_bus();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
